irq_sequencer: RTL and testbench
================================

Name: irq_sequencer

Overview:
- Interrupt controller for the 16-bit core; owns the decoder's IEN input.
- Latches up to four interrupt requests, applies a mask and a global enable, and picks one winner by fixed priority.
- At an instruction boundary it sequences entry: one IEN cycle makes the decoder push the return state, then a vector handshake loads the PC.
- Tracks the in-service interrupt until RETI.

Parameters:
N_IRQ, 4, number of request lines (index 0 = highest priority)
ADDR_W, 16, vector address width
VEC_BASE, 16'h0010, address of the vector for IRQ 0
VEC_STRIDE, 4, address spacing between consecutive vectors

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
irq  in  N_IRQ  request levels, already synchronous to clk
mask_wr  in  1  write strobe for the mask register
mask_din  in  N_IRQ  new mask value (1 = source enabled)
ion  in  1  ION instruction pulse; sets the global enable
iof  in  1  IOF instruction pulse; clears the global enable
inst_done  in  1  current instruction completes this cycle
reti  in  1  return-from-interrupt pulse
vec_ack  in  1  PC logic has taken vec_addr
ien  out  1  to decoder; forces the return-state push for one cycle
vec_valid  out  1  vec_addr is valid
vec_addr  out  ADDR_W  vector of the accepted IRQ
irq_active  out  1  an ISR is in service
isr_id  out  clog2(N_IRQ)  index of the in-service IRQ
pending  out  N_IRQ  pending register, for observation

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE; gie=0; mask=0; pending=0; isr_id=0; ien=0; vec_valid=0; vec_addr=0; irq_active=0.
- Reset asserted mid-sequence aborts it; no partial ien or vec_valid pulse may follow.
- Edge capture:
  - irq_q holds the previous sample of irq.
  - pending[i] sets on a rising edge (irq[i] & ~irq_q[i]) and is visible on the next cycle.
  - Masked sources still latch pending.
  - If an edge and the acceptance-clear hit the same bit in the same cycle, the set wins.
- Mask: mask_wr loads mask_din at the clock edge. The new mask takes effect in the eligibility check on the following cycle.
- Global enable (gie):
  - ion sets gie; iof clears it; iof wins if both arrive together.
  - Entry clears gie; RETI sets it.
- Eligibility: elig = pending & mask. Winner = lowest set index of elig.
- FSM:
  - IDLE: if gie & |elig & inst_done, latch isr_id=winner, clear pending[winner] and gie, go to PUSH. Otherwise stay.
  - PUSH: ien=1 for exactly one cycle, then go to VECTOR.
  - VECTOR:
    - vec_valid=1 and vec_addr = VEC_BASE + isr_id*VEC_STRIDE (ADDR_W bits, wraps modulo 2^ADDR_W).
    - Both hold stable until vec_ack is sampled high.
    - vec_ack in the first VECTOR cycle is legal.
    - Then go to SERVICE.
  - SERVICE: irq_active=1. On reti set gie=1 and go to IDLE; isr_id holds its last value.
- No nesting: new edges only accumulate in pending while not in IDLE.
- reti outside SERVICE is ignored. vec_ack outside VECTOR is ignored.
- ion during PUSH, VECTOR or SERVICE updates gie, but gie is only consulted in IDLE.
- Latency: irq edge at cycle t → pending visible at t+1 → earliest entry decision at t+1 (if inst_done) → ien at t+2 → vec_valid from t+3.

Decomposition:
- Package irq_seq_pkg holds: the state encoding (IDLE, PUSH, VECTOR, SERVICE), N_IRQ/ADDR_W defaults, VEC_BASE/VEC_STRIDE, and the priority-encoder function.
- One sub-module, irq_edge_latch: the irq_q register, rising-edge detect, and the pending register with set-wins clear.
- The FSM, gie, mask and vector arithmetic stay in the top module.

Test Plan:
- Reset, then mask=4'b1111, ion, irq[2] rising, inst_done=1 → ien one cycle, vec_valid with vec_addr=16'h0018, vec_ack → irq_active=1, isr_id=2, pending[2]=0.
- irq[3] and irq[1] rise together, entry → isr_id=1, vec_addr=16'h0014, pending=4'b1000. After reti → second entry for IRQ 3, vec_addr=16'h001C.
- mask=4'b0000, irq[0] rises → pending=4'b0001, no ien. Write mask=4'b0001 → entry follows on the first inst_done.
- ion and iof in the same cycle → gie=0, no entry. With inst_done held 0 → no entry despite an eligible pending bit.
- vec_ack withheld 5 cycles → vec_valid and vec_addr stable throughout. rst_n low during VECTOR → all outputs 0 immediately; no vec_valid after release.
- irq[1] edge in the same cycle pending[1] is accepted → pending[1]=1 afterwards. reti during IDLE → ignored, gie unchanged.

Source files
------------

// File: rtl/irq_seq_pkg.sv
// Shared definitions for the interrupt sequencer: defaults, FSM encoding,
// and the fixed-priority encoder used to pick a winning request.
package irq_seq_pkg;

    localparam int          N_IRQ_DEF      = 4;
    localparam int          ADDR_W_DEF     = 16;
    localparam logic [15:0] VEC_BASE_DEF   = 16'h0010;
    localparam int          VEC_STRIDE_DEF = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PUSH    = 2'd1,
        VECTOR  = 2'd2,
        SERVICE = 2'd3
    } irq_state_e;

    // Index of the lowest set bit (index 0 = highest priority); 0 when empty.
    function automatic int unsigned lowest_set(input logic [31:0] v);
        int unsigned idx;
        idx = 0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/irq_edge_latch.sv
// Rising-edge capture of the request lines into a sticky pending register.
// A new edge on a bit beats a same-cycle clear of that bit, so a request
// that re-fires while being accepted is never lost.
module irq_edge_latch #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] irq_i,
    input  logic [N-1:0] clr_i,
    output logic [N-1:0] pending_o
);

    logic [N-1:0] irq_q;
    logic [N-1:0] pend_q;
    logic [N-1:0] pend_d;
    logic [N-1:0] rise;

    assign rise      = irq_i & ~irq_q;
    assign pend_d    = (pend_q & ~clr_i) | rise;
    assign pending_o = pend_q;

    // Previous-sample register and pending bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q  <= '0;
            pend_q <= '0;
        end else begin
            irq_q  <= irq_i;
            pend_q <= pend_d;
        end
    end

endmodule

// File: rtl/irq_sequencer.sv
// Interrupt sequencer: masks pending requests, picks a winner by fixed
// priority at an instruction boundary, pulses ien for the return-state
// push, hands the vector to the PC logic, then tracks the ISR until reti.
module irq_sequencer
    import irq_seq_pkg::*;
#(
    parameter int                N_IRQ      = N_IRQ_DEF,
    parameter int                ADDR_W     = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] VEC_BASE   = ADDR_W'(VEC_BASE_DEF),
    parameter int                VEC_STRIDE = VEC_STRIDE_DEF,
    localparam int               IDW        = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_IRQ-1:0]  irq,
    input  logic              mask_wr,
    input  logic [N_IRQ-1:0]  mask_din,
    input  logic              ion,
    input  logic              iof,
    input  logic              inst_done,
    input  logic              reti,
    input  logic              vec_ack,
    output logic              ien,
    output logic              vec_valid,
    output logic [ADDR_W-1:0] vec_addr,
    output logic              irq_active,
    output logic [IDW-1:0]    isr_id,
    output logic [N_IRQ-1:0]  pending
);

    irq_state_e        state_q;
    logic              gie_q;
    logic [N_IRQ-1:0]  mask_q;
    logic [IDW-1:0]    isr_id_q;
    logic              ien_q;
    logic              vec_valid_q;
    logic [ADDR_W-1:0] vec_addr_q;
    logic              active_q;

    logic [N_IRQ-1:0]  pend;
    logic [N_IRQ-1:0]  elig;
    logic [N_IRQ-1:0]  clr;
    logic [IDW-1:0]    winner;
    logic              accept;
    logic [ADDR_W-1:0] vec_calc;

    irq_edge_latch #(.N(N_IRQ)) u_edge (
        .clk       (clk),
        .rst_n     (rst_n),
        .irq_i     (irq),
        .clr_i     (clr),
        .pending_o (pend)
    );

    // Entry decision and the one-hot clear of the accepted pending bit.
    always_comb begin
        elig   = pend & mask_q;
        winner = IDW'(lowest_set(32'(elig)));
        accept = (state_q == IDLE) && gie_q && (|elig) && inst_done;
        clr    = '0;
        if (accept) clr[winner] = 1'b1;
    end

    // Vector address wraps naturally at ADDR_W bits.
    assign vec_calc = VEC_BASE + ADDR_W'(isr_id_q) * ADDR_W'(VEC_STRIDE);

    // Mask register; the new value is seen by the eligibility check next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       mask_q <= '0;
        else if (mask_wr) mask_q <= mask_din;
    end

    // Entry sequencer with global enable and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gie_q       <= 1'b0;
            isr_id_q    <= '0;
            ien_q       <= 1'b0;
            vec_valid_q <= 1'b0;
            vec_addr_q  <= '0;
            active_q    <= 1'b0;
        end else begin
            // ion/iof act in any state; iof wins. Entry/reti below override.
            if (iof)      gie_q <= 1'b0;
            else if (ion) gie_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        isr_id_q <= winner;
                        gie_q    <= 1'b0;
                        ien_q    <= 1'b1;
                        state_q  <= PUSH;
                    end
                end
                PUSH: begin
                    ien_q       <= 1'b0;
                    vec_valid_q <= 1'b1;
                    vec_addr_q  <= vec_calc;
                    state_q     <= VECTOR;
                end
                VECTOR: begin
                    if (vec_ack) begin
                        vec_valid_q <= 1'b0;
                        active_q    <= 1'b1;
                        state_q     <= SERVICE;
                    end
                end
                SERVICE: begin
                    if (reti) begin
                        active_q <= 1'b0;
                        gie_q    <= 1'b1;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ien        = ien_q;
    assign vec_valid  = vec_valid_q;
    assign vec_addr   = vec_addr_q;
    assign irq_active = active_q;
    assign isr_id     = isr_id_q;
    assign pending    = pend;

endmodule

// File: tb/tb_irq_sequencer.sv
// Bench for irq_sequencer: directed scenarios with fixed expectations, then
// randomized traffic compared every cycle against a timing-level model.
module tb_irq_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  irq = '0;
    logic        mask_wr = 1'b0;
    logic [3:0]  mask_din = '0;
    logic        ion = 1'b0;
    logic        iof = 1'b0;
    logic        inst_done = 1'b0;
    logic        reti = 1'b0;
    logic        vec_ack = 1'b0;
    logic        ien;
    logic        vec_valid;
    logic [15:0] vec_addr;
    logic        irq_active;
    logic [1:0]  isr_id;
    logic [3:0]  pending;

    int total = 0;
    int bad   = 0;

    irq_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .irq        (irq),
        .mask_wr    (mask_wr),
        .mask_din   (mask_din),
        .ion        (ion),
        .iof        (iof),
        .inst_done  (inst_done),
        .reti       (reti),
        .vec_ack    (vec_ack),
        .ien        (ien),
        .vec_valid  (vec_valid),
        .vec_addr   (vec_addr),
        .irq_active (irq_active),
        .isr_id     (isr_id),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Tracks an ISR as "edges since acceptance" plus an acknowledged flag:
    // ien one cycle after acceptance, vector offered from then until acked.
    logic [3:0] m_prev, m_pend, m_mask;
    logic       m_gie, m_busy, m_acked;
    int         m_t, m_id;
    logic [3:0] m_elig;
    logic       m_acc;
    int         m_win;

    function automatic int first_set(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return 0;
    endfunction

    assign m_elig = m_pend & m_mask;
    assign m_acc  = !m_busy && m_gie && (m_elig != 4'b0) && inst_done;
    assign m_win  = first_set(m_elig);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_prev <= '0; m_pend <= '0; m_mask <= '0; m_gie <= 1'b0;
            m_busy <= 1'b0; m_acked <= 1'b0; m_t <= 0; m_id <= 0;
        end else begin
            m_prev <= irq;
            m_pend <= (m_acc ? (m_pend & ~(4'b0001 << m_win)) : m_pend) | (irq & ~m_prev);
            if (mask_wr) m_mask <= mask_din;
            if (ion) m_gie <= 1'b1;
            if (iof) m_gie <= 1'b0;
            if (m_acc) m_gie <= 1'b0;
            if (m_busy && m_acked && reti) m_gie <= 1'b1;
            if (m_acc) begin
                m_busy <= 1'b1; m_t <= 0; m_acked <= 1'b0; m_id <= m_win;
            end else if (m_busy) begin
                if (m_t < 1)                  m_t <= m_t + 1;
                else if (!m_acked && vec_ack) m_acked <= 1'b1;
                else if (m_acked && reti)     m_busy <= 1'b0;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic quiet();
        mask_wr = 0; ion = 0; iof = 0; reti = 0; vec_ack = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 0; irq = 0; inst_done = 0; quiet();
        step(); step();
        total++; if (ien !== 1'b0)        begin bad++; $display("FAIL reset_ien got=%0b want=0", ien); end
        total++; if (vec_valid !== 1'b0)  begin bad++; $display("FAIL reset_vv got=%0b want=0", vec_valid); end
        total++; if (vec_addr !== 16'h0)  begin bad++; $display("FAIL reset_addr got=%h want=0000", vec_addr); end
        total++; if (irq_active !== 1'b0) begin bad++; $display("FAIL reset_act got=%0b want=0", irq_active); end
        total++; if (isr_id !== 2'd0)     begin bad++; $display("FAIL reset_id got=%0d want=0", isr_id); end
        total++; if (pending !== 4'h0)    begin bad++; $display("FAIL reset_pend got=%b want=0000", pending); end
        rst_n = 1;
        step();
        total++; if (ien !== 1'b0) begin bad++; $display("FAIL reset_rel_ien got=%0b want=0", ien); end
    endtask

    task automatic test_basic();
        mask_wr = 1; mask_din = 4'hF; ion = 1;
        step(); quiet();
        irq = 4'b0100; inst_done = 1;
        step();
        total++; if (pending !== 4'b0100) begin bad++; $display("FAIL basic_pend got=%b want=0100", pending); end
        total++; if (ien !== 1'b0)        begin bad++; $display("FAIL basic_ien_early got=%0b want=0", ien); end
        step();
        total++; if (ien !== 1'b1)        begin bad++; $display("FAIL basic_ien got=%0b want=1", ien); end
        total++; if (isr_id !== 2'd2)     begin bad++; $display("FAIL basic_id got=%0d want=2", isr_id); end
        total++; if (pending !== 4'b0000) begin bad++; $display("FAIL basic_pend_clr got=%b want=0000", pending); end
        step();
        total++; if (ien !== 1'b0)        begin bad++; $display("FAIL basic_ien_once got=%0b want=0", ien); end
        total++; if (vec_valid !== 1'b1)  begin bad++; $display("FAIL basic_vv got=%0b want=1", vec_valid); end
        total++; if (vec_addr !== 16'h0018) begin bad++; $display("FAIL basic_addr got=%h want=0018", vec_addr); end
        vec_ack = 1;
        step(); quiet();
        total++; if (vec_valid !== 1'b0)  begin bad++; $display("FAIL basic_vv_drop got=%0b want=0", vec_valid); end
        total++; if (irq_active !== 1'b1) begin bad++; $display("FAIL basic_act got=%0b want=1", irq_active); end
        total++; if (isr_id !== 2'd2)     begin bad++; $display("FAIL basic_id_svc got=%0d want=2", isr_id); end
        irq = 0; reti = 1;
        step(); quiet();
        total++; if (irq_active !== 1'b0) begin bad++; $display("FAIL basic_reti got=%0b want=0", irq_active); end
    endtask

    task automatic test_priority();
        irq = 4'b1010; inst_done = 1;
        step();
        total++; if (pending !== 4'b1010) begin bad++; $display("FAIL prio_pend got=%b want=1010", pending); end
        step();
        total++; if (ien !== 1'b1 || isr_id !== 2'd1) begin bad++; $display("FAIL prio_first got ien=%0b id=%0d want ien=1 id=1", ien, isr_id); end
        total++; if (pending !== 4'b1000) begin bad++; $display("FAIL prio_pend_left got=%b want=1000", pending); end
        step();
        total++; if (vec_addr !== 16'h0014) begin bad++; $display("FAIL prio_addr1 got=%h want=0014", vec_addr); end
        vec_ack = 1; step(); quiet();
        reti = 1; step(); quiet();
        total++; if (ien !== 1'b0 || irq_active !== 1'b0) begin bad++; $display("FAIL prio_gap got ien=%0b act=%0b want 0 0", ien, irq_active); end
        step();
        total++; if (ien !== 1'b1 || isr_id !== 2'd3) begin bad++; $display("FAIL prio_second got ien=%0b id=%0d want ien=1 id=3", ien, isr_id); end
        step();
        total++; if (vec_valid !== 1'b1 || vec_addr !== 16'h001C) begin bad++; $display("FAIL prio_addr3 got vv=%0b addr=%h want 1 001c", vec_valid, vec_addr); end
        vec_ack = 1; step(); quiet();
        reti = 1; step(); quiet();
        irq = 0; inst_done = 0;
        step();
    endtask

    task automatic test_mask();
        mask_wr = 1; mask_din = 4'b0000;
        step(); quiet();
        irq = 4'b0001; inst_done = 1;
        step();
        total++; if (pending !== 4'b0001) begin bad++; $display("FAIL mask_pend got=%b want=0001", pending); end
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (ien !== 1'b0) begin bad++; $display("FAIL mask_blocked got=%0b want=0", ien); end
        end
        mask_wr = 1; mask_din = 4'b0001;
        step(); quiet();
        total++; if (ien !== 1'b0) begin bad++; $display("FAIL mask_delay got=%0b want=0", ien); end
        step();
        total++; if (ien !== 1'b1 || isr_id !== 2'd0) begin bad++; $display("FAIL mask_entry got ien=%0b id=%0d want ien=1 id=0", ien, isr_id); end
        step();
        total++; if (vec_addr !== 16'h0010) begin bad++; $display("FAIL mask_addr got=%h want=0010", vec_addr); end
        vec_ack = 1; step(); quiet();
        reti = 1; step(); quiet();
        irq = 0; inst_done = 0;
        step();
    endtask

    task automatic test_gie();
        mask_wr = 1; mask_din = 4'hF;
        irq = 4'b0010; ion = 1; iof = 1; inst_done = 1;
        step(); quiet();
        total++; if (pending !== 4'b0010) begin bad++; $display("FAIL gie_pend got=%b want=0010", pending); end
        for (int i = 0; i < 4; i++) begin
            step();
            total++; if (ien !== 1'b0) begin bad++; $display("FAIL gie_iof_wins got=%0b want=0", ien); end
        end
        reti = 1; step(); quiet();
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (ien !== 1'b0 || irq_active !== 1'b0) begin bad++; $display("FAIL gie_reti_idle got ien=%0b act=%0b want 0 0", ien, irq_active); end
        end
        inst_done = 0; ion = 1;
        step(); quiet();
        for (int i = 0; i < 4; i++) begin
            step();
            total++; if (ien !== 1'b0) begin bad++; $display("FAIL gie_no_boundary got=%0b want=0", ien); end
        end
        inst_done = 1;
        step();
        total++; if (ien !== 1'b1 || isr_id !== 2'd1) begin bad++; $display("FAIL gie_entry got ien=%0b id=%0d want ien=1 id=1", ien, isr_id); end
        step();
        vec_ack = 1; step(); quiet();
        reti = 1; step(); quiet();
        irq = 0; inst_done = 0;
        step();
    endtask

    task automatic test_stall_reset();
        irq = 4'b0001; inst_done = 1;
        step(); step();
        total++; if (ien !== 1'b1) begin bad++; $display("FAIL stall_ien got=%0b want=1", ien); end
        for (int i = 0; i < 6; i++) begin
            step();
            total++; if (vec_valid !== 1'b1 || vec_addr !== 16'h0010) begin bad++; $display("FAIL stall_hold got vv=%0b addr=%h want 1 0010", vec_valid, vec_addr); end
        end
        irq = 0;
        #2 rst_n = 0;
        #1;
        total++; if ({ien, vec_valid, irq_active} !== 3'b000) begin bad++; $display("FAIL stall_rst_ctl got=%b want=000", {ien, vec_valid, irq_active}); end
        total++; if (vec_addr !== 16'h0 || isr_id !== 2'd0 || pending !== 4'h0) begin bad++; $display("FAIL stall_rst_data got addr=%h id=%0d pend=%b want 0", vec_addr, isr_id, pending); end
        @(negedge clk);
        rst_n = 1; vec_ack = 1;
        for (int i = 0; i < 6; i++) begin
            step();
            total++; if (vec_valid !== 1'b0 || ien !== 1'b0) begin bad++; $display("FAIL stall_after got vv=%0b ien=%0b want 0 0", vec_valid, ien); end
        end
        quiet(); inst_done = 0;
    endtask

    task automatic test_set_wins();
        mask_wr = 1; mask_din = 4'hF; ion = 1;
        step(); quiet();
        irq = 4'b0010;
        step();
        total++; if (pending !== 4'b0010) begin bad++; $display("FAIL setw_pend got=%b want=0010", pending); end
        irq = 0;
        step();
        irq = 4'b0010; inst_done = 1;
        step();
        total++; if (ien !== 1'b1 || isr_id !== 2'd1) begin bad++; $display("FAIL setw_entry got ien=%0b id=%0d want ien=1 id=1", ien, isr_id); end
        total++; if (pending !== 4'b0010) begin bad++; $display("FAIL setw_kept got=%b want=0010", pending); end
        inst_done = 0;
        step();
        vec_ack = 1; step(); quiet();
        reti = 1; step(); quiet();
        inst_done = 1;
        step();
        total++; if (ien !== 1'b1 || pending !== 4'b0000) begin bad++; $display("FAIL setw_again got ien=%0b pend=%b want 1 0000", ien, pending); end
        step();
        vec_ack = 1; step(); quiet();
        reti = 1; step(); quiet();
        irq = 0; inst_done = 0;
    endtask

    task automatic test_random();
        logic [15:0] e_addr;
        rst_n = 0; irq = 0; inst_done = 0; quiet();
        step();
        rst_n = 1;
        for (int c = 0; c < 600; c++) begin
            e_addr = 16'h0010 + 16'(m_id * 4);
            total++; if (ien !== (m_busy && m_t == 0)) begin bad++; $display("FAIL rnd_ien c=%0d got=%0b want=%0b", c, ien, (m_busy && m_t == 0)); end
            total++; if (vec_valid !== (m_busy && m_t >= 1 && !m_acked)) begin bad++; $display("FAIL rnd_vv c=%0d got=%0b want=%0b", c, vec_valid, (m_busy && m_t >= 1 && !m_acked)); end
            total++; if (irq_active !== (m_busy && m_acked)) begin bad++; $display("FAIL rnd_act c=%0d got=%0b want=%0b", c, irq_active, (m_busy && m_acked)); end
            total++; if (isr_id !== 2'(m_id)) begin bad++; $display("FAIL rnd_id c=%0d got=%0d want=%0d", c, isr_id, m_id); end
            total++; if (pending !== m_pend) begin bad++; $display("FAIL rnd_pend c=%0d got=%b want=%b", c, pending, m_pend); end
            if (vec_valid === 1'b1) begin
                total++; if (vec_addr !== e_addr) begin bad++; $display("FAIL rnd_addr c=%0d got=%h want=%h", c, vec_addr, e_addr); end
            end
            for (int i = 0; i < 4; i++) if ($urandom_range(0, 5) == 0) irq[i] = ~irq[i];
            mask_wr   = ($urandom_range(0, 9) == 0);
            mask_din  = 4'($urandom_range(0, 15));
            ion       = ($urandom_range(0, 3) == 0);
            iof       = ($urandom_range(0, 11) == 0);
            inst_done = ($urandom_range(0, 1) == 0);
            vec_ack   = ($urandom_range(0, 2) == 0);
            reti      = ($urandom_range(0, 3) == 0);
            step();
        end
        quiet(); irq = 0; inst_done = 0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_priority();
        test_mask();
        test_gie();
        test_stall_reset();
        test_set_wins();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
